// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing CommuteCore's single memory access channel between the Core (port 0) and the loader (port 1).
// Define MEM_ACCESS_ARBITER_PERF_COUNTER_EN to add the perfGrant0/perfGrant1/perfStall counters.
module mem_access_arbiter #(
    parameter int SERIAL_WIDTH = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64
) (
    input  logic                    clk,
    input  logic                    negResetIn,
    input  logic                    req0RE,
    input  logic                    req0WE,
    input  logic [ADDR_WIDTH-1:0]   req0Addr,
    input  logic [DATA_WIDTH-1:0]   req0WData,
    input  logic                    req1RE,
    input  logic                    req1WE,
    input  logic [ADDR_WIDTH-1:0]   req1Addr,
    input  logic [DATA_WIDTH-1:0]   req1WData,
    output logic                    grant0,
    output logic                    grant1,
    output logic [SERIAL_WIDTH-1:0] grantSerial,
    output logic                    memAccessRE,
    output logic                    memAccessWE,
    output logic [ADDR_WIDTH-1:0]   memAccessAddr,
    output logic [DATA_WIDTH-1:0]   memAccessWriteData,
    input  logic                    memAccessReadBusy,
    input  logic                    memAccessWriteBusy,
    input  logic [SERIAL_WIDTH-1:0] nextMemReadSerial,
    input  logic [SERIAL_WIDTH-1:0] nextMemWriteSerial,
    input  logic                    memReadDataReady,
    input  logic [DATA_WIDTH-1:0]   memReadData,
    input  logic [SERIAL_WIDTH-1:0] memReadSerial,
    input  logic                    memWriteAckValid,
    input  logic [SERIAL_WIDTH-1:0] memWriteAckSerial,
    output logic                    rsp0ReadValid,
    output logic                    rsp1ReadValid,
    output logic [DATA_WIDTH-1:0]   rspReadData,
    output logic [SERIAL_WIDTH-1:0] rspSerial,
    output logic                    rsp0WriteAck,
    output logic                    rsp1WriteAck,
    output logic                    idle,
`ifdef MEM_ACCESS_ARBITER_PERF_COUNTER_EN
    output logic [31:0]             perfGrant0,
    output logic [31:0]             perfGrant1,
    output logic [31:0]             perfStall,
`endif
    output logic                    errUnexpectedRsp
);

    localparam int DEPTH = 1 << SERIAL_WIDTH;

    // Owner tables: valid bit per serial, owner bit is the issuing port index.
    logic [DEPTH-1:0] r_rdValid;
    logic [DEPTH-1:0] r_rdOwner;
    logic [DEPTH-1:0] r_wrValid;
    logic [DEPTH-1:0] r_wrOwner;
    logic             r_rrPtr;
    logic             r_err;

    logic w_req0Rd, w_req0Wr, w_req1Rd, w_req1Wr;
    logic w_rdOk, w_wrOk;
    logic w_elig0, w_elig1;
    logic w_win0, w_win1, w_grant, w_winRd;
    logic w_rdHit, w_rdOwn, w_wrHit, w_wrOwn;

    // A simultaneous RE+WE is a read; the write is dropped for that cycle.
    assign w_req0Rd = req0RE;
    assign w_req0Wr = req0WE & ~req0RE;
    assign w_req1Rd = req1RE;
    assign w_req1Wr = req1WE & ~req1RE;

    assign w_rdOk = ~memAccessReadBusy  & ~r_rdValid[nextMemReadSerial];
    assign w_wrOk = ~memAccessWriteBusy & ~r_wrValid[nextMemWriteSerial];

    assign w_elig0 = (w_req0Rd & w_rdOk) | (w_req0Wr & w_wrOk);
    assign w_elig1 = (w_req1Rd & w_rdOk) | (w_req1Wr & w_wrOk);

    assign w_win0  = w_elig0 & (~w_elig1 | ~r_rrPtr);
    assign w_win1  = w_elig1 & (~w_elig0 |  r_rrPtr);
    assign w_grant = w_win0 | w_win1;
    assign w_winRd = w_win1 ? w_req1Rd : w_req0Rd;

    assign grant0      = w_win0;
    assign grant1      = w_win1;
    assign memAccessRE = w_grant & w_winRd;
    assign memAccessWE = w_grant & ~w_winRd;
    assign memAccessAddr      = w_win0 ? req0Addr  : (w_win1 ? req1Addr  : '0);
    assign memAccessWriteData = w_win0 ? req0WData : (w_win1 ? req1WData : '0);
    assign grantSerial = memAccessRE ? nextMemReadSerial :
                         (memAccessWE ? nextMemWriteSerial : '0);

    assign w_rdHit = memReadDataReady & r_rdValid[memReadSerial];
    assign w_rdOwn = r_rdOwner[memReadSerial];
    assign w_wrHit = memWriteAckValid & r_wrValid[memWriteAckSerial];
    assign w_wrOwn = r_wrOwner[memWriteAckSerial];

    assign rsp0ReadValid = w_rdHit & ~w_rdOwn;
    assign rsp1ReadValid = w_rdHit &  w_rdOwn;
    assign rspReadData   = w_rdHit ? memReadData   : '0;
    assign rspSerial     = w_rdHit ? memReadSerial : '0;
    assign rsp0WriteAck  = w_wrHit & ~w_wrOwn;
    assign rsp1WriteAck  = w_wrHit &  w_wrOwn;

    assign idle             = ~(|r_rdValid | |r_wrValid);
    assign errUnexpectedRsp = r_err;

    // Issue sets an entry only when it is clear, so a set and a clear never collide.
    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            r_rdValid <= '0;
            r_rdOwner <= '0;
            r_wrValid <= '0;
            r_wrOwner <= '0;
            r_rrPtr   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_rdHit) r_rdValid[memReadSerial]     <= 1'b0;
            if (w_wrHit) r_wrValid[memWriteAckSerial] <= 1'b0;
            if (memAccessRE) begin
                r_rdValid[nextMemReadSerial] <= 1'b1;
                r_rdOwner[nextMemReadSerial] <= w_win1;
            end
            if (memAccessWE) begin
                r_wrValid[nextMemWriteSerial] <= 1'b1;
                r_wrOwner[nextMemWriteSerial] <= w_win1;
            end
            if (w_grant) r_rrPtr <= w_win0;
            if ((memReadDataReady & ~w_rdHit) | (memWriteAckValid & ~w_wrHit))
                r_err <= 1'b1;
        end
    end

`ifdef MEM_ACCESS_ARBITER_PERF_COUNTER_EN
    logic [31:0] r_perfGrant0, r_perfGrant1, r_perfStall;
    logic        w_anyReq;

    assign w_anyReq = req0RE | req0WE | req1RE | req1WE;

    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            r_perfGrant0 <= '0;
            r_perfGrant1 <= '0;
            r_perfStall  <= '0;
        end else begin
            if (w_win0) r_perfGrant0 <= r_perfGrant0 + 32'd1;
            if (w_win1) r_perfGrant1 <= r_perfGrant1 + 32'd1;
            if (w_anyReq & ~w_grant) r_perfStall <= r_perfStall + 32'd1;
        end
    end

    assign perfGrant0 = r_perfGrant0;
    assign perfGrant1 = r_perfGrant1;
    assign perfStall  = r_perfStall;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed scenarios plus randomized traffic against an owner-table model.
module tb_mem_access_arbiter;

    localparam int SW = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          negResetIn;
    logic          req0RE, req0WE, req1RE, req1WE;
    logic [AW-1:0] req0Addr, req1Addr;
    logic [DW-1:0] req0WData, req1WData;
    logic          grant0, grant1;
    logic [SW-1:0] grantSerial;
    logic          memAccessRE, memAccessWE;
    logic [AW-1:0] memAccessAddr;
    logic [DW-1:0] memAccessWriteData;
    logic          memAccessReadBusy, memAccessWriteBusy;
    logic [SW-1:0] nextMemReadSerial, nextMemWriteSerial;
    logic          memReadDataReady;
    logic [DW-1:0] memReadData;
    logic [SW-1:0] memReadSerial;
    logic          memWriteAckValid;
    logic [SW-1:0] memWriteAckSerial;
    logic          rsp0ReadValid, rsp1ReadValid;
    logic [DW-1:0] rspReadData;
    logic [SW-1:0] rspSerial;
    logic          rsp0WriteAck, rsp1WriteAck;
    logic          idle, errUnexpectedRsp;
`ifdef MEM_ACCESS_ARBITER_PERF_COUNTER_EN
    logic [31:0]   perfGrant0, perfGrant1, perfStall;
`endif

    always #5 clk = ~clk;

    mem_access_arbiter #(.SERIAL_WIDTH(SW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .negResetIn(negResetIn),
        .req0RE(req0RE), .req0WE(req0WE), .req0Addr(req0Addr), .req0WData(req0WData),
        .req1RE(req1RE), .req1WE(req1WE), .req1Addr(req1Addr), .req1WData(req1WData),
        .grant0(grant0), .grant1(grant1), .grantSerial(grantSerial),
        .memAccessRE(memAccessRE), .memAccessWE(memAccessWE),
        .memAccessAddr(memAccessAddr), .memAccessWriteData(memAccessWriteData),
        .memAccessReadBusy(memAccessReadBusy), .memAccessWriteBusy(memAccessWriteBusy),
        .nextMemReadSerial(nextMemReadSerial), .nextMemWriteSerial(nextMemWriteSerial),
        .memReadDataReady(memReadDataReady), .memReadData(memReadData), .memReadSerial(memReadSerial),
        .memWriteAckValid(memWriteAckValid), .memWriteAckSerial(memWriteAckSerial),
        .rsp0ReadValid(rsp0ReadValid), .rsp1ReadValid(rsp1ReadValid),
        .rspReadData(rspReadData), .rspSerial(rspSerial),
        .rsp0WriteAck(rsp0WriteAck), .rsp1WriteAck(rsp1WriteAck),
        .idle(idle),
`ifdef MEM_ACCESS_ARBITER_PERF_COUNTER_EN
        .perfGrant0(perfGrant0), .perfGrant1(perfGrant1), .perfStall(perfStall),
`endif
        .errUnexpectedRsp(errUnexpectedRsp)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Reference model: per-serial owner port (-1 = free), round-robin favourite, sticky error.
    int m_rr;
    int m_rdOwn[NS];
    int m_wrOwn[NS];
    bit m_err;
    int m_nr, m_nw;
    int e_win;
    bit e_rd;

    task automatic model_reset();
        m_rr = 0;
        m_err = 0;
        m_nr = 0;
        m_nw = 0;
        for (int i = 0; i < NS; i++) begin
            m_rdOwn[i] = -1;
            m_wrOwn[i] = -1;
        end
    endtask

    task automatic inputs_idle();
        req0RE = 0; req0WE = 0; req1RE = 0; req1WE = 0;
        req0Addr = '0; req1Addr = '0; req0WData = '0; req1WData = '0;
        memAccessReadBusy = 0; memAccessWriteBusy = 0;
        nextMemReadSerial = '0; nextMemWriteSerial = '0;
        memReadDataReady = 0; memReadData = '0; memReadSerial = '0;
        memWriteAckValid = 0; memWriteAckSerial = '0;
    endtask

    task automatic do_reset();
        inputs_idle();
        negResetIn = 0;
        #2;
        chk("rst_idle",  64'(idle), 64'(1));
        chk("rst_err",   64'(errUnexpectedRsp), 64'(0));
        chk("rst_grant", 64'({grant0, grant1}), 64'(0));
        chk("rst_memRW", 64'({memAccessRE, memAccessWE}), 64'(0));
        chk("rst_rsp",   64'({rsp0ReadValid, rsp1ReadValid, rsp0WriteAck, rsp1WriteAck}), 64'(0));
        model_reset();
        #3 negResetIn = 1;
        @(posedge clk);
        #1;
    endtask

    // Check one cycle's combinational outputs against the model, then advance the model at the edge.
    task automatic step();
        bit r0, w0, r1, w1, rdOk, wrOk, e0, e1, wrd, rhit, whit, mi;
        int win, rs, ws, nr, nw;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        #1;
        r0 = req0RE; w0 = req0WE && !req0RE;
        r1 = req1RE; w1 = req1WE && !req1RE;
        nr = int'(nextMemReadSerial);
        nw = int'(nextMemWriteSerial);
        rdOk = !memAccessReadBusy && (m_rdOwn[nr] < 0);
        wrOk = !memAccessWriteBusy && (m_wrOwn[nw] < 0);
        e0 = (r0 && rdOk) || (w0 && wrOk);
        e1 = (r1 && rdOk) || (w1 && wrOk);
        if (e0 && e1) win = m_rr;
        else if (e0)  win = 0;
        else if (e1)  win = 1;
        else          win = -1;
        wrd = (win == 1) ? r1 : r0;
        ea = (win == 0) ? req0Addr  : ((win == 1) ? req1Addr  : '0);
        ed = (win == 0) ? req0WData : ((win == 1) ? req1WData : '0);
        chk("grant0", 64'(grant0), 64'(win == 0));
        chk("grant1", 64'(grant1), 64'(win == 1));
        chk("memRE",  64'(memAccessRE), 64'(win >= 0 && wrd));
        chk("memWE",  64'(memAccessWE), 64'(win >= 0 && !wrd));
        chk("memAddr", 64'(memAccessAddr), 64'(ea));
        chk("memWData", memAccessWriteData, ed);
        if (win >= 0) chk("gserial", 64'(grantSerial), 64'(wrd ? nr : nw));
        rs = int'(memReadSerial);
        ws = int'(memWriteAckSerial);
        rhit = memReadDataReady && (m_rdOwn[rs] >= 0);
        whit = memWriteAckValid && (m_wrOwn[ws] >= 0);
        chk("rsp0RV", 64'(rsp0ReadValid), 64'(rhit && m_rdOwn[rs] == 0));
        chk("rsp1RV", 64'(rsp1ReadValid), 64'(rhit && m_rdOwn[rs] == 1));
        if (rhit) begin
            chk("rspData", rspReadData, memReadData);
            chk("rspSer", 64'(rspSerial), 64'(rs));
        end
        chk("rsp0WA", 64'(rsp0WriteAck), 64'(whit && m_wrOwn[ws] == 0));
        chk("rsp1WA", 64'(rsp1WriteAck), 64'(whit && m_wrOwn[ws] == 1));
        mi = 1;
        for (int i = 0; i < NS; i++) if (m_rdOwn[i] >= 0 || m_wrOwn[i] >= 0) mi = 0;
        chk("idle", 64'(idle), 64'(mi));
        chk("err", 64'(errUnexpectedRsp), 64'(m_err));
        e_win = win;
        e_rd = wrd;
        @(posedge clk);
        if (rhit) m_rdOwn[rs] = -1;
        else if (memReadDataReady) m_err = 1;
        if (whit) m_wrOwn[ws] = -1;
        else if (memWriteAckValid) m_err = 1;
        if (win >= 0) begin
            if (wrd) m_rdOwn[nr] = win;
            else     m_wrOwn[nw] = win;
            m_rr = 1 - win;
        end
        #1;
    endtask

    initial begin
        negResetIn = 1;
        inputs_idle();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // First read from port 0.
        req0RE = 1; req0Addr = 32'h100; nextMemReadSerial = 2'd2;
        #1;
        chk("t1_grant0", 64'(grant0), 64'(1));
        chk("t1_addr", 64'(memAccessAddr), 64'h100);
        chk("t1_serial", 64'(grantSerial), 64'(2));
        step();
        req0RE = 0;
        #1 chk("t1_idle", 64'(idle), 64'(0));
        step();

        // Round-robin alternation.
        do_reset();
        req0RE = 1; req1RE = 1;
        for (int i = 0; i < 4; i++) begin
            nextMemReadSerial = SW'(i);
            #1 chk("rr_order", 64'(grant1), 64'(i % 2));
            step();
        end

        // Port-1 read routed back to port 1.
        do_reset();
        req1RE = 1; nextMemReadSerial = 2'd1;
        step();
        req1RE = 0; memReadDataReady = 1; memReadSerial = 2'd1; memReadData = 64'hDEAD;
        #1;
        chk("t3_rsp1", 64'(rsp1ReadValid), 64'(1));
        chk("t3_rsp0", 64'(rsp0ReadValid), 64'(0));
        chk("t3_data", rspReadData, 64'hDEAD);
        step();
        memReadDataReady = 0;
        #1 chk("t3_idle", 64'(idle), 64'(1));
        step();

        // RE+WE together is a read.
        req0RE = 1; req0WE = 1; nextMemReadSerial = 2'd3;
        #1 chk("norm_we", 64'({memAccessRE, memAccessWE}), 64'b10);
        step();

        // Serial wrap stall.
        do_reset();
        req0RE = 1;
        for (int s = 0; s < NS; s++) begin
            nextMemReadSerial = SW'(s);
            step();
        end
        nextMemReadSerial = 2'd0;
        #1 chk("wrap_stall", 64'(grant0), 64'(0));
        step();
        memReadDataReady = 1; memReadSerial = 2'd0; memReadData = 64'h55;
        #1 chk("wrap_stall_rsp", 64'(grant0), 64'(0));
        step();
        memReadDataReady = 0;
        #1 chk("wrap_resume", 64'(grant0), 64'(1));
        step();

        // Unexpected write ack is sticky until reset.
        do_reset();
        memWriteAckValid = 1; memWriteAckSerial = 2'd3;
        #1 chk("unexp_ack", 64'({rsp0WriteAck, rsp1WriteAck}), 64'(0));
        step();
        memWriteAckValid = 0;
        step();
        step();
        chk("err_sticky", 64'(errUnexpectedRsp), 64'(1));
        do_reset();

        // Write busy lets port 1 read through; port-0 write follows when free.
        memAccessWriteBusy = 1; req0WE = 1; req1RE = 1; nextMemWriteSerial = 2'd1;
        #1 chk("wbusy_g", 64'({grant0, grant1}), 64'b01);
        step();
        req1RE = 0;
        #1 chk("wbusy_hold", 64'(grant0), 64'(0));
        step();
        memAccessWriteBusy = 0;
        #1 chk("wbusy_go", 64'({grant0, memAccessWE}), 64'b11);
        step();

        // Reset drops an outstanding read; its late response is an error.
        do_reset();
        req1RE = 1; nextMemReadSerial = 2'd2;
        step();
        do_reset();
        memReadDataReady = 1; memReadSerial = 2'd2;
        #1 chk("late_rsp", 64'(rsp1ReadValid), 64'(0));
        step();
        memReadDataReady = 0;
        #1 chk("late_err", 64'(errUnexpectedRsp), 64'(1));
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            req0RE = ($urandom % 3 == 0);
            req0WE = ($urandom % 2 == 0);
            req1RE = ($urandom % 3 == 0);
            req1WE = ($urandom % 2 == 0);
            req0Addr = $urandom; req1Addr = $urandom;
            req0WData = {$urandom, $urandom}; req1WData = {$urandom, $urandom};
            memAccessReadBusy  = ($urandom % 5 == 0);
            memAccessWriteBusy = ($urandom % 5 == 0);
            nextMemReadSerial  = ($urandom % 10 == 0) ? SW'($urandom) : SW'(m_nr);
            nextMemWriteSerial = ($urandom % 10 == 0) ? SW'($urandom) : SW'(m_nw);
            memReadDataReady = 0;
            memWriteAckValid = 0;
            if ($urandom % 2 == 0) begin
                int s;
                s = $urandom % NS;
                if (m_rdOwn[s] >= 0 || (i > 1200 && $urandom % 8 == 0)) begin
                    memReadDataReady = 1; memReadSerial = SW'(s); memReadData = {$urandom, $urandom};
                end
            end
            if ($urandom % 2 == 0) begin
                int s;
                s = $urandom % NS;
                if (m_wrOwn[s] >= 0 || (i > 1200 && $urandom % 8 == 0)) begin
                    memWriteAckValid = 1; memWriteAckSerial = SW'(s);
                end
            end
            step();
            if (e_win >= 0) begin
                if (e_rd) m_nr = (m_nr + 1) % NS;
                else      m_nw = (m_nw + 1) % NS;
            end
            if (i == 1000) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
